// File: rtl/omem_responder_if.sv
// Array access bus and host drain stream of the output-memory responder.
// master = array/host side, slave = responder.
interface omem_responder_if #(
    parameter int AW = 4,
    parameter int DW = 64
);
    logic          EN_O;
    logic          RW_O;
    logic [AW-1:0] ADDR_O;
    logic [DW-1:0] WDATA_O;
    logic [DW-1:0] RDATA_O;
    logic          D_VALID;
    logic          D_READY;
    logic [DW-1:0] D_DATA;
    logic [AW-1:0] D_ADDR;

    modport master (
        output EN_O, RW_O, ADDR_O, WDATA_O, D_READY,
        input  RDATA_O, D_VALID, D_DATA, D_ADDR
    );

    modport slave (
        input  EN_O, RW_O, ADDR_O, WDATA_O, D_READY,
        output RDATA_O, D_VALID, D_DATA, D_ADDR
    );
endinterface

// File: rtl/omem_responder.sv
// Output-memory responder: OMEM for the MAC array, fill tracking and a valid/ready drain engine.
// Define OMEM_PARITY_EN to add per-entry even parity with a sticky PERR flag.
module omem_responder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 64
) (
    input  logic            CLK,
    input  logic            RST,
    omem_responder_if.slave bus,
    input  logic [AW:0]     FILL_TARGET,
    input  logic            CLEAR,
    output logic            ALL_VALID,
    output logic [AW:0]     FILL_CNT,
    input  logic            DRAIN_START,
    output logic            DRAIN_BUSY,
    output logic            DRAIN_DONE,
    output logic            PERR
);
    typedef enum logic [1:0] {IDLE, RD, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] vbit;
    logic [AW:0]      fill_cnt;
    logic [AW:0]      tgt_lat;
    logic [AW:0]      eff_target;
    logic [AW-1:0]    ptr;
    logic [DW-1:0]    rdata;
    logic [DW-1:0]    d_data;
    logic             done;
    logic             perr;
    logic             perr_set;
    logic             arr_rd;
    logic             arr_wr;
    logic             drain_rd;
    logic             accept;
    logic             last;
    logic             done_nxt;

    assign arr_rd     = bus.EN_O & ~bus.RW_O;
    assign arr_wr     = bus.EN_O & bus.RW_O;
    assign eff_target = (FILL_TARGET == '0) ? (AW+1)'(DEPTH) : FILL_TARGET;
    assign last       = ({1'b0, ptr} == tgt_lat - (AW+1)'(1));

    assign bus.RDATA_O = rdata;
    assign bus.D_DATA  = d_data;
    assign bus.D_ADDR  = ptr;
    assign FILL_CNT    = fill_cnt;
    assign ALL_VALID   = (fill_cnt == eff_target);
    assign DRAIN_DONE  = done;
    assign PERR        = perr;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // The array owns the port: a drain read only happens in RD on a cycle with EN_O low.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (DRAIN_START) state_nxt = RD;
            RD:      if (!bus.EN_O) state_nxt = HOLD;
            HOLD:    if (bus.D_READY) state_nxt = last ? IDLE : RD;
            default: state_nxt = IDLE;
        endcase
        if (CLEAR) state_nxt = IDLE;
    end

    always_comb begin
        drain_rd    = (state == RD) && !bus.EN_O;
        accept      = (state == HOLD) && bus.D_READY;
        done_nxt    = accept && last && !CLEAR;
        bus.D_VALID = (state == HOLD);
        DRAIN_BUSY  = (state != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (arr_wr) mem[bus.ADDR_O] <= bus.WDATA_O;
    end

`ifdef OMEM_PARITY_EN
    logic [DEPTH-1:0] par;

    always_ff @(posedge CLK) begin
        if (arr_wr) par[bus.ADDR_O] <= ^bus.WDATA_O;
    end

    // Entries never written since the last clear hold stale parity, so only tracked entries are checked.
    assign perr_set = (arr_rd && vbit[bus.ADDR_O] && ((^mem[bus.ADDR_O]) != par[bus.ADDR_O])) ||
                      (drain_rd && vbit[ptr] && ((^mem[ptr]) != par[ptr]));
`else
    assign perr_set = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            vbit     <= '0;
            fill_cnt <= '0;
            tgt_lat  <= '0;
            ptr      <= '0;
            rdata    <= '0;
            d_data   <= '0;
            done     <= 1'b0;
            perr     <= 1'b0;
        end else begin
            done <= done_nxt;
            if (arr_rd)   rdata  <= mem[bus.ADDR_O];
            if (drain_rd) d_data <= mem[ptr];

            if (state == IDLE && DRAIN_START) tgt_lat <= eff_target;
            if (accept) ptr <= last ? '0 : ptr + AW'(1);

            // A completed drain retires the tile exactly like CLEAR, minus the abort.
            if (CLEAR || done_nxt) begin
                vbit     <= '0;
                fill_cnt <= '0;
                ptr      <= '0;
            end else if (arr_wr && !vbit[bus.ADDR_O]) begin
                vbit[bus.ADDR_O] <= 1'b1;
                if (fill_cnt != (AW+1)'(DEPTH)) fill_cnt <= fill_cnt + (AW+1)'(1);
            end

            if (CLEAR)         perr <= 1'b0;
            else if (perr_set) perr <= 1'b1;
        end
    end
endmodule

// File: doc/omem_responder.md
Name: omem_responder

Overview:
Memory-side responder for the MAC array's output-memory port (EN_O/RW_O/ADDR_O/WDATA_O -> RDATA_O). It holds the 16x64 OMEM, serves array reads and writes with 1-cycle read latency, and tracks which entries have been written. It also streams completed results to a host sink over a valid/ready drain port, giving way to the array on each cycle the array uses the port.

Parameters:
DEPTH, 16, number of OMEM entries (power of 2)
AW, 4, address width, log2(DEPTH)
DW, 64, data word width

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
EN_O  in  1  array access enable
RW_O  in  1  1 = write, 0 = read
ADDR_O  in  AW  array address
WDATA_O  in  DW  array write data
RDATA_O  out  DW  array read data, registered
FILL_TARGET  in  AW+1  number of entries per tile, 1..DEPTH; 0 is treated as DEPTH
CLEAR  in  1  clears tracking state and aborts any drain
ALL_VALID  out  1  fill count equals the effective target
FILL_CNT  out  AW+1  number of distinct entries written since the last clear
DRAIN_START  in  1  pulse: stream entries 0..target-1 to the sink
DRAIN_BUSY  out  1  drain FSM is not IDLE
D_VALID  out  1  drain word is valid
D_READY  in  1  sink accepts the drain word
D_DATA  out  DW  drain word
D_ADDR  out  AW  address of the drain word
DRAIN_DONE  out  1  one-cycle pulse after the last word is accepted
PERR  out  1  sticky parity error (only with OMEM_PARITY_EN)

Behaviour:
- Reset: all outputs 0, valid bitmap 0, FILL_CNT 0, FSM IDLE, drain pointer 0. Memory array contents are not reset.
- Array write (EN_O=1, RW_O=1):
  - mem[ADDR_O] <= WDATA_O at the clock edge.
  - If vbit[ADDR_O] was 0, set it and increment FILL_CNT. A rewrite of a set entry leaves the count unchanged.
  - RDATA_O holds its value.
- Array read (EN_O=1, RW_O=0): RDATA_O = mem[ADDR_O] on the next cycle. It holds otherwise.
- Write then read: a write at cycle t followed by a read of the same address at t+1 returns the new data at t+2.
- ALL_VALID: combinational, equals (FILL_CNT == effective target). FILL_CNT saturates at DEPTH.
- Drain FSM, IDLE -> RD -> HOLD:
  - IDLE: DRAIN_START=1 -> RD with ptr=0. DRAIN_START is ignored in any other state.
  - RD, EN_O=1: the array has priority; stay in RD and issue no internal read.
  - RD, EN_O=0: read mem[ptr]. Next cycle: D_DATA=mem[ptr], D_ADDR=ptr, D_VALID=1, state HOLD.
  - HOLD, D_READY=0: D_VALID, D_DATA and D_ADDR are held stable.
  - HOLD, D_READY=1, ptr < target-1: D_VALID=0, ptr++, go to RD.
  - HOLD, D_READY=1, ptr = target-1: D_VALID=0 and DRAIN_DONE=1 for one cycle; clear the bitmap and FILL_CNT; go to IDLE.
- Drain throughput: at most 1 word per 2 cycles, plus 1 cycle per array-collision stall.
- An array write during a drain to an entry not yet drained is visible to the drain.
- CLEAR=1 (priority over everything except RST):
  - Bitmap and FILL_CNT go to 0; the FSM goes to IDLE; D_VALID goes to 0; DRAIN_DONE is not pulsed.
  - An array write in the same cycle still updates memory but does not set its vbit.
- RST mid-drain: same as power-on reset.
- The effective target is latched at DRAIN_START. FILL_TARGET changes during a drain have no effect.

Optional Feature:
Macro OMEM_PARITY_EN.
- Defined:
  - Each entry stores an even-parity bit computed from WDATA_O on every write.
  - Parity is checked on every array read and drain read of an entry whose vbit is 1.
  - A mismatch sets PERR, which is sticky until RST or CLEAR.
  - Reads of entries whose vbit is 0 are never checked.
- Undefined: no parity storage; PERR is tied to 0.

Test Plan:
- Reset, then write addr 0..15 with data 64'h1000_0000_0000_0000+addr, FILL_TARGET=0 -> FILL_CNT goes 1..16 one per write; ALL_VALID=1 after the 16th write.
- Write addr 5 = 64'hDEAD_BEEF_0000_0005, read addr 5 next cycle -> RDATA_O=64'hDEAD_BEEF_0000_0005 exactly 1 cycle after the read; rewrite addr 5 -> FILL_CNT unchanged.
- FILL_TARGET=4, entries 0..3 filled, DRAIN_START, D_READY held low 3 cycles per word -> D_ADDR 0,1,2,3 with data stable while stalled; DRAIN_DONE single pulse; then FILL_CNT=0 and ALL_VALID=0.
- Drain in RD while the array drives EN_O=1 for 2 cycles -> drain read delayed exactly 2 cycles; array RDATA_O correct; drain data correct.
- CLEAR asserted in HOLD of word 2 -> D_VALID=0 next cycle, no DRAIN_DONE, DRAIN_BUSY=0, FILL_CNT=0; a new DRAIN_START restarts at addr 0.
- With OMEM_PARITY_EN: normal traffic -> PERR stays 0; backdoor flip of bit 7 of entry 3, then read addr 3 -> PERR=1 and stays 1 until CLEAR.
